// File: rtl/decode_queue.sv
// decode_queue: handshaked mini-MIPS instruction decoder followed by a
// DEPTH-entry FIFO that feeds the register-read/execute stage.
//
// Each accepted instruction is decoded combinationally on entry. Its
// class (R/I/J/illegal), extended immediate and PC are stored next to
// the raw word. The head entry drives the out_* fields, which read zero
// whenever the queue is empty. A flush empties the queue in one edge,
// for use on branch redirects.
//
// Optional build macro: DECODE_ZERO_EXT_LOGIC_EN
//   defined   -> andi/ori/xori (0x0C/0x0D/0x0E) zero-extend the immediate
//   undefined -> every opcode sign-extends the immediate
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          upstream handshake; in_instr, in_pc payload
//   flush                      discard every queued entry
//   out_valid/out_ready        downstream handshake on the head entry
//   out_opcode..out_addr       instruction fields of the head entry
//   out_type                   0=R, 1=I, 2=J, 3=illegal
//   out_imm, out_pc            extended immediate and PC of the head entry
//   fifo_count                 number of occupied entries
//   illegal_cnt                saturating count of accepted illegal words
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IMM_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_opcode,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [5:0]               out_funct,
  output logic [IMM_W-1:0]         out_imm,
  output logic [25:0]              out_addr,
  output logic [1:0]               out_type,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Entry storage (no reset needed: an entry is only read while valid)
  logic [31:0]      r_instr_mem [DEPTH];
  logic [PC_W-1:0]  r_pc_mem    [DEPTH];
  logic [1:0]       r_type_mem  [DEPTH];
  logic [IMM_W-1:0] r_imm_mem   [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_illegal_cnt;

  logic [1:0]       w_type;
  logic [IMM_W-1:0] w_imm;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head_instr;

  // ---------------------------------------------------------------
  // Decode of the incoming word
  // ---------------------------------------------------------------
  always_comb begin
    w_type = 2'd3;
    case (in_instr[31:26])
      6'h00: w_type = 2'd0;
      6'h02, 6'h03: w_type = 2'd2;
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h23, 6'h2B:
        w_type = 2'd1;
      default: w_type = 2'd3;
    endcase
  end

  always_comb begin
    w_imm = IMM_W'($signed(in_instr[15:0]));
`ifdef DECODE_ZERO_EXT_LOGIC_EN
    // Logical immediates treat the 16-bit field as unsigned
    if (in_instr[31:26] == 6'h0C || in_instr[31:26] == 6'h0D ||
        in_instr[31:26] == 6'h0E) begin
      w_imm = IMM_W'(in_instr[15:0]);
    end
`else
    w_imm = IMM_W'($signed(in_instr[15:0]));
`endif
  end

  // ---------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------
  // No bypass when full: a pop in the same cycle does not open in_ready.
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // ---------------------------------------------------------------
  // Storage write
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= in_instr;
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_type_mem[r_wr_ptr]  <= w_type;
      r_imm_mem[r_wr_ptr]   <= w_imm;
    end
  end

  // ---------------------------------------------------------------
  // Pointers, occupancy and illegal counter
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_illegal_cnt <= '0;
    end else if (flush) begin
      // Write pointer is left where it was, so the dropped push leaves no trace
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push && (w_type == 2'd3) && (r_illegal_cnt != '1)) begin
        r_illegal_cnt <= r_illegal_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Head outputs, zeroed while the queue is empty
  // ---------------------------------------------------------------
  assign w_head_instr = out_valid ? r_instr_mem[r_rd_ptr] : 32'd0;

  assign out_opcode  = w_head_instr[31:26];
  assign out_rs      = w_head_instr[25:21];
  assign out_rt      = w_head_instr[20:16];
  assign out_rd      = w_head_instr[15:11];
  assign out_shamt   = w_head_instr[10:6];
  assign out_funct   = w_head_instr[5:0];
  assign out_addr    = w_head_instr[25:0];
  assign out_type    = out_valid ? r_type_mem[r_rd_ptr] : 2'd0;
  assign out_imm     = out_valid ? r_imm_mem[r_rd_ptr]  : '0;
  assign out_pc      = out_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign fifo_count  = r_count;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, handshaked successor to the combinational instruction decoder.
- Accepts 32-bit mini-MIPS instructions with their PC over a valid/ready interface.
- Decodes all fields and classifies each instruction as R/I/J/illegal; unknown opcodes are explicitly marked illegal and counted.
- Queues decoded entries in a parametrised FIFO ahead of the register-read/execute stage, with flush support for branch redirects.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PC_W, 32, width of the PC carried alongside each instruction.
- IMM_W, 32, width of the extended immediate; >= 16.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  decoder can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction address.
- flush  in  1  discard all queued entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head.
- out_opcode  out  6  instr[31:26].
- out_rs  out  5  instr[25:21].
- out_rt  out  5  instr[20:16].
- out_rd  out  5  instr[15:11].
- out_shamt  out  5  instr[10:6].
- out_funct  out  6  instr[5:0].
- out_imm  out  IMM_W  extended instr[15:0].
- out_addr  out  26  instr[25:0].
- out_type  out  2  0=R, 1=I, 2=J, 3=illegal.
- out_pc  out  PC_W  PC of head entry.
- fifo_count  out  log2(DEPTH)+1  occupied entries.
- illegal_cnt  out  CNT_W  accepted illegal instructions, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Read/write pointers, fifo_count, out_valid and illegal_cnt go to 0.
  - All out_* fields read 0.
  - Reset mid-stream discards all entries; nothing is replayed.
- Push: occurs when in_valid && in_ready at a clock edge.
  - Decode is combinational on in_instr; the decoded entry is written at the write pointer.
- in_ready = (fifo_count < DEPTH). No same-cycle full-FIFO bypass: when full, in_ready=0 even if out_ready=1.
- Pop: occurs when out_valid && out_ready.
- out_valid = (fifo_count != 0).
- Latency: an instruction pushed at edge N appears at the outputs after edge N when the FIFO was empty (1 cycle).
- All out_* fields are driven from the head entry and are forced to 0 while out_valid=0.
- Head fields hold stable while out_valid && !out_ready.
- Simultaneous push and pop: fifo_count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Classification (out_type):
  - Opcode 0x00 -> 0 (R).
  - Opcodes 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0E, 0x0F, 0x12–0x17, 0x23, 0x2B -> 1 (I).
  - Opcodes 0x02, 0x03 -> 2 (J).
  - Every other opcode -> 3 (illegal); never a held or latched value.
- Immediate: sign-extended from instr[15] to IMM_W, except as modified by the optional feature.
- illegal_cnt: increments by 1 on each push with type 3; saturates at all-ones.
- flush: at the edge where flush=1:
  - fifo_count goes to 0 and read pointer = write pointer.
  - Any same-cycle push and pop are discarded.
  - in_ready stays driven by the pre-flush count that cycle.
  - illegal_cnt does not count an illegal instruction dropped by flush.
- Fields are extracted from the same bit positions regardless of type; consumers qualify them with out_type.

Optional Feature:
- Macro: DECODE_ZERO_EXT_LOGIC_EN.
- Defined: opcodes 0x0C, 0x0D, 0x0E (andi/ori/xori) zero-extend instr[15:0] into out_imm; all other opcodes sign-extend.
- Undefined: every opcode sign-extends.
- Classification and all other behaviour are identical in both builds.

Test Plan:
- R-type: push 0x012A4020 with pc 0x100 into an empty FIFO, out_ready=1 -> one cycle later out_valid=1, opcode 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20, type 0, pc 0x100; fifo_count returns to 0 after the pop.
- Immediate extension:
  - 0x2128FFFF (addi) -> type 1, rs 9, rt 8, imm 0xFFFFFFFF.
  - 0x3528FFFF (ori) -> imm 0xFFFFFFFF without the macro, 0x0000FFFF with DECODE_ZERO_EXT_LOGIC_EN.
- J and illegal:
  - 0x08000010 -> type 2, addr 0x0000010.
  - 0xFC000000 -> type 3, illegal_cnt 0 -> 1.
  - Then 0x00000000 -> type 0, illegal_cnt stays 1.
- Backpressure (DEPTH=4): out_ready=0, push 5 back-to-back -> in_ready falls after the 4th accept, fifo_count=4, head fields stable. Raise out_ready -> entries drain in push order; the 5th is accepted the cycle after in_ready rises.
- Flush: queue 3 entries including one illegal, assert flush with a simultaneous push of 0xFC000000 -> next cycle fifo_count=0, out_valid=0, illegal_cnt reflects only the earlier accepted illegal.
- Reset mid-operation: with 2 entries queued and in_valid=1, pulse rst_n low between clock edges -> out_valid, fifo_count and illegal_cnt go to 0 immediately; after release the first new push appears with 1-cycle latency.
